smvm_issue_sched: RTL
=====================

SMVM_ISSUE_SCHED -- requirements
Module: smvm_issue_sched

Interface
REQ-001 Parameter K, default 4: number of ALU lanes per issued batch.
REQ-002 Parameter OBUF, default 8: result slots in the downstream output buffer (credit pool).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  nonzero-entry beat valid.
REQ-006 in_ready  output  1  scheduler accepts a beat this cycle.
REQ-007 in_val  input  8  signed matrix value.
REQ-008 in_col  input  7  column index (0..127).
REQ-009 in_ipv  input  1  1 = entry is the last nonzero of its row.
REQ-010 in_last  input  1  1 = entry is the last nonzero of the matrix.
REQ-011 iss_valid  output  1  one-cycle batch issue strobe to ALU L1.
REQ-012 iss_val  output  8*K  lane values; lane 0 at [8K-1 -: 8].
REQ-013 iss_col  output  7*K  lane column indices; lane 0 at [7K-1 -: 7].
REQ-014 iss_ipv  output  K  lane IPV bits; lane 0 at bit K-1.
REQ-015 iss_ones  output  3  count of 1s in iss_ipv (row results produced by batch).
REQ-016 out_pop  input  1  downstream drained one result; returns one credit.
REQ-017 done  output  1  one-cycle pulse: matrix fully issued and all results drained.
REQ-018 rows_cnt  output  8  total rows issued since reset/last done.
REQ-019 err  output  1  sticky: out_pop received with credit pool full.

Function
REQ-020 FSM states FILL, ISSUE, DRAIN; reset state FILL.
REQ-021 FILL: in_ready=1; accepted beat (in_valid & in_ready) written to lane lane_cnt, lane_cnt increments.
REQ-022 FILL -> ISSUE when accepted beat has lane_cnt==K-1 or in_last=1; lane_cnt returns to 0.
REQ-023 Partial batch on in_last: unfilled lanes padded val=0, col=0, ipv=0.
REQ-024 ISSUE: in_ready=0; iss_valid=1 in the first cycle with iss_ones <= credit; otherwise hold ISSUE, outputs stable.
REQ-025 iss_val/iss_col/iss_ipv/iss_ones are zero whenever iss_valid=0.
REQ-026 ISSUE -> FILL after issue if batch not last; ISSUE -> DRAIN after issue if batch contained in_last.
REQ-027 Latency: beat completing a batch accepted in cycle N -> iss_valid in cycle N+1 when credit suffices.
REQ-028 credit: 4-bit, reset OBUF; on issue credit -= iss_ones; on out_pop credit += 1; both same cycle: credit = credit - iss_ones + 1.
REQ-029 out_pop when credit==OBUF and no same-cycle issue: credit unchanged, err set until rst.
REQ-030 DRAIN: in_ready=0; when credit==OBUF (after any same-cycle pop), done=1 for one cycle, FSM -> FILL, rows_cnt cleared the following cycle.
REQ-031 rows_cnt += iss_ones on each issue; saturates at 255.
REQ-032 Batch with iss_ones=0 issues regardless of credit (row spanning batches).
REQ-033 in_ipv ignored for credit until its batch issues; no credit reserved during FILL.

Reset
REQ-034 rst=1 at any clock edge, including mid-batch or in DRAIN: FSM=FILL, lane_cnt=0, lane registers 0, credit=OBUF, rows_cnt=0, err=0; partial batch discarded.
REQ-035 During and the cycle after reset: iss_valid=0, done=0, in_ready=0 while rst=1, in_ready=1 first cycle after release.

Verification
REQ-036 4 beats vals 1,2,3,4 cols 5,6,7,8 ipv 0,1,0,1, in_last on 4th -> next cycle iss_valid=1, iss_val=0x01020304, iss_ipv=4'b0101, iss_ones=2; DRAIN; 2 out_pop -> done pulse, rows_cnt=2 before clear.
REQ-037 2 beats ipv 1,1 with in_last -> lanes 2,3 padded zero, iss_ipv=4'b1100, iss_ones=2.
REQ-038 Credit stall: issue 2 full batches ipv=4'b1111 without pops (credit 0); third batch waits in ISSUE with in_ready=0; 1 pop -> still stalled; 4 pops total -> issue next cycle.
REQ-039 Simultaneous issue (ones=3) and out_pop at credit=3 -> credit=1, no err.
REQ-040 out_pop at credit=8 -> err=1 stays set; rst=1 mid-FILL with 2 lanes loaded -> err=0, next batch starts at lane 0.

Source files
------------

// File: rtl/smvm_issue_sched.sv
// SpMV issue scheduler: packs CSR nonzeros into K-lane ALU batches
// and gates issue on output-buffer credits for completed rows.
module smvm_issue_sched #(
  parameter int K    = 4,
  parameter int OBUF = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7:0]     in_val,
  input  logic [6:0]     in_col,
  input  logic           in_ipv,
  input  logic           in_last,
  output logic           iss_valid,
  output logic [8*K-1:0] iss_val,
  output logic [7*K-1:0] iss_col,
  output logic [K-1:0]   iss_ipv,
  output logic [2:0]     iss_ones,
  input  logic           out_pop,
  output logic           done,
  output logic [7:0]     rows_cnt,
  output logic           err
);

  localparam int LW = $clog2(K + 1);
  localparam logic [3:0] FULL = 4'(OBUF);

  typedef enum logic [1:0] {
    FILL,
    ISSUE,
    DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [LW-1:0]  lane_cnt;
  logic [8*K-1:0] val_r;
  logic [7*K-1:0] col_r;
  logic [K-1:0]   ipv_r;
  logic           last_r;
  logic [3:0]     credit;
  logic [3:0]     avail;
  logic [3:0]     credit_nxt;
  logic [2:0]     ones;
  logic [8:0]     rows_sum;
  logic [7:0]     rows_sat;
  logic           accept;
  logic           batch_end;
  logic           iss_go;
  logic           pop_ok;
  logic           pop_err;

  always_comb begin
    ones = '0;
    for (int i = 0; i < K; i++) begin
      ones = ones + 3'(ipv_r[i]);
    end
  end

  assign accept    = in_valid && in_ready;
  assign batch_end = accept &&
                     (lane_cnt == LW'(K - 1) || in_last);

  // zero-row batches always fit, so they never stall
  assign iss_go = !rst && (state == ISSUE) &&
                  ({1'b0, ones} <= credit);

  // a pop that would overflow the pool is dropped and flagged
  assign avail      = credit - (iss_go ? {1'b0, ones} : 4'd0);
  assign pop_err    = out_pop && (avail == FULL);
  assign pop_ok     = out_pop && !pop_err;
  assign credit_nxt = avail + {3'd0, pop_ok};

  assign rows_sum = {1'b0, rows_cnt} + {6'd0, ones};
  assign rows_sat = rows_sum[8] ? 8'hFF : rows_sum[7:0];

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:    if (batch_end) state_nxt = ISSUE;
      ISSUE:   if (iss_go) state_nxt = last_r ? DRAIN : FILL;
      DRAIN:   if (done) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    in_ready  = !rst && (state == FILL);
    iss_valid = iss_go;
    iss_val   = iss_go ? val_r : '0;
    iss_col   = iss_go ? col_r : '0;
    iss_ipv   = iss_go ? ipv_r : '0;
    iss_ones  = iss_go ? ones : '0;
    done      = !rst && (state == DRAIN) &&
                (credit_nxt == FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt <= '0;
      val_r    <= '0;
      col_r    <= '0;
      ipv_r    <= '0;
      last_r   <= 1'b0;
      credit   <= FULL;
      rows_cnt <= '0;
      err      <= 1'b0;
    end else begin
      // clearing on issue makes a short final batch zero-padded
      if (iss_go) begin
        val_r <= '0;
        col_r <= '0;
        ipv_r <= '0;
      end else if (accept) begin
        for (int i = 0; i < K; i++) begin
          if (lane_cnt == LW'(i)) begin
            val_r[8*(K-i)-1 -: 8] <= in_val;
            col_r[7*(K-i)-1 -: 7] <= in_col;
            ipv_r[K-1-i]          <= in_ipv;
          end
        end
      end
      if (accept) begin
        lane_cnt <= batch_end ? '0 : lane_cnt + LW'(1);
      end
      if (batch_end) last_r <= in_last;
      credit <= credit_nxt;
      if (pop_err) err <= 1'b1;
      if (done)        rows_cnt <= '0;
      else if (iss_go) rows_cnt <= rows_sat;
    end
  end

endmodule
